// File: rtl/seq_mult8.sv
// Iterative 8x8 unsigned shift-add multiplier controller driving an external
// 8-bit adder stage; one add/shift step per clock, 16-bit product after 8 steps.
module seq_mult8 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        busy,
    output logic        done,
    output logic [15:0] product,
    output logic [7:0]  add_x,
    output logic [7:0]  add_y,
    output logic        add_cin,
    input  logic [7:0]  add_s,
    input  logic        add_c
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  acc_q, acc_d;
    logic [7:0]  mq_q, mq_d;
    logic [7:0]  mcand_q, mcand_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] product_q, product_d;
    logic [15:0] step;

    // Carry-out becomes the new MSB so the 9-bit step sum is never truncated.
    assign step = {add_c, add_s, mq_q[7:1]};

    assign add_x   = acc_q;
    assign add_y   = mq_q[0] ? mcand_q : '0;
    assign add_cin = 1'b0;

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign product = product_q;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        mcand_d   = mcand_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d = a;
                    mq_d    = b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                {acc_d, mq_d} = step;
                cnt_d         = cnt_q + 4'd1;
                if (cnt_q == 4'd7) begin
                    product_d = step;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            mq_q      <= '0;
            mcand_q   <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mq_q      <= mq_d;
            mcand_q   <= mcand_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

endmodule

// File: tb/tb_seq_mult8.sv
// Scoreboard bench for seq_mult8: driver queues expected products, a negedge
// monitor checks product, latency, done width, busy length and product hold.
module tb_seq_mult8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  a_in, b_in;
    logic        busy, done;
    logic [15:0] product;
    logic [7:0]  add_x, add_y, add_s;
    logic        add_cin, add_c;

    typedef struct {
        logic [15:0] prod;
        int          acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    seq_mult8 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a_in),
        .b       (b_in),
        .busy    (busy),
        .done    (done),
        .product (product),
        .add_x   (add_x),
        .add_y   (add_y),
        .add_cin (add_cin),
        .add_s   (add_s),
        .add_c   (add_c)
    );

    // Behavioural model of the external 8-bit adder stage.
    assign {add_c, add_s} = {1'b0, add_x} + {1'b0, add_y} + {8'b0, add_cin};

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    logic        prev_done = 1'b0;
    logic [15:0] last_prod = '0;
    int          busy_len = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_done = 1'b0;
            last_prod = '0;
            busy_len  = 0;
            chk("reset_product", {16'h0, product}, 32'h0);
        end else begin
            chk("add_cin", {31'h0, add_cin}, 32'h0);
            if (done) begin
                exp_t e;
                chk("done_width", {31'h0, prev_done}, 32'h0);
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_done: got done with empty scoreboard, product=%0h (cycle %0d)", product, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("product", {16'h0, product}, {16'h0, e.prod});
                    chk("latency", cyc - e.acc_cyc, 32'd8);
                    last_prod = e.prod;
                end
            end else begin
                chk("product_hold", {16'h0, product}, {16'h0, last_prod});
            end
            if (busy) begin
                busy_len++;
            end else if (busy_len != 0) begin
                chk("busy_len", busy_len, 32'd9);
                busy_len = 0;
            end
            prev_done = done;
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy) timeout("wait_idle");
    endtask

    task automatic start_op(input logic [7:0] x, input logic [7:0] y, input logic [15:0] p);
        wait_idle();
        a_in  = x;
        b_in  = y;
        start = 1'b1;
        sb.push_back('{p, cyc + 1});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0 || busy) timeout("drain");
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int c0;
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        #1;
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_product", {16'h0, product}, 32'h0);
        chk("rst_add_x", {24'h0, add_x}, 32'h0);
        chk("rst_add_y", {24'h0, add_y}, 32'h0);
        #16 rst_n = 1'b1;

        start_op(8'd13, 8'd11, 16'd143);
        drain();
        start_op(8'hFF, 8'hFF, 16'hFE01);
        start_op(8'h80, 8'h02, 16'h0100);
        start_op(8'h00, 8'hA5, 16'h0000);
        start_op(8'hA5, 8'h01, 16'h00A5);
        drain();

        // Start requests during RUN and DONE must be ignored.
        start_op(8'd200, 8'd100, 16'd20000);
        repeat (2) @(negedge clk);
        a_in  = 8'd3;
        b_in  = 8'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!done) timeout("wait_done");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ignored_start_idle", {31'h0, busy}, 32'h0);
        repeat (6) @(negedge clk);
        drain();

        // Start held high: back-to-back accepts ten cycles apart.
        wait_idle();
        a_in  = 8'd7;
        b_in  = 8'd6;
        start = 1'b1;
        c0    = cyc;
        sb.push_back('{16'd42, c0 + 1});
        sb.push_back('{16'd81, c0 + 11});
        @(negedge clk);
        a_in = 8'd9;
        b_in = 8'd9;
        repeat (10) @(negedge clk);
        start = 1'b0;
        chk("b2b_second_accept", {31'h0, busy}, 32'h1);
        drain();

        // Asynchronous reset in the 4th RUN cycle aborts the operation.
        start_op(8'd100, 8'd50, 16'd5000);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_done", {31'h0, done}, 32'h0);
        chk("abort_product", {16'h0, product}, 32'h0);
        chk("abort_add_x", {24'h0, add_x}, 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (15) @(negedge clk);
        start_op(8'd5, 8'd5, 16'd25);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
